// File: rtl/intc_ctrl.sv
// intc_ctrl: memory-mapped interrupt controller with per-source mask, edge/level select and a claim register.
// Optional build macro INTC_SYNC_EN adds a 2-flop synchronizer ahead of the source sample register.
module intc_ctrl #(
   parameter int unsigned N_SRC    = 6,
   parameter logic [7:0]  MASK_RST = 8'h00,
   parameter logic [7:0]  EDGE_RST = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src_irq,
   input  logic [29:0]      Addr,
   input  logic             WE,
   input  logic [31:0]      Din,
   output logic [31:0]      Dout,
   output logic [N_SRC-1:0] hwint,
   output logic             irq
);

   typedef enum logic [1:0] {
      REG_PEND  = 2'd0,
      REG_MASK  = 2'd1,
      REG_EDGE  = 2'd2,
      REG_CLAIM = 2'd3
   } reg_sel_e;

   // Index of the lowest set bit; index 0 wins. Returns 0 for an all-zero vector.
   function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         idx = v[i] ? 3'(i) : idx;
      end
      return idx;
   endfunction

   logic [N_SRC-1:0] cur_q;
   logic [N_SRC-1:0] prev_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] edge_q, edge_d;
   logic [N_SRC-1:0] sample_s;
   logic [N_SRC-1:0] rise_s;
   logic [N_SRC-1:0] clr_s;
   logic [31:0]      claim_s;
   reg_sel_e         sel_s;
   logic             wr_pend_s;
   logic             wr_mask_s;
   logic             wr_edge_s;
   logic             wr_claim_s;
   logic             unused_s;

   assign unused_s = ^{Addr[29:2], Din[31:N_SRC]};

`ifdef INTC_SYNC_EN
   logic [N_SRC-1:0] sync1_q;
   logic [N_SRC-1:0] sync2_q;

   // Two-stage synchronizer for sources that are asynchronous to clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= {N_SRC{1'b0}};
         sync2_q <= {N_SRC{1'b0}};
      end else begin
         sync1_q <= src_irq;
         sync2_q <= sync1_q;
      end
   end

   assign sample_s = sync2_q;
`else
   assign sample_s = src_irq;
`endif

   // Register address decode and write strobes.
   always_comb begin
      sel_s      = reg_sel_e'(Addr[1:0]);
      wr_pend_s  = WE && (sel_s == REG_PEND);
      wr_mask_s  = WE && (sel_s == REG_MASK);
      wr_edge_s  = WE && (sel_s == REG_EDGE);
      wr_claim_s = WE && (sel_s == REG_CLAIM);
   end

   // Per-source clear requests from PEND W1C and CLAIM acknowledge; out-of-range ids match no bit.
   always_comb begin
      clr_s = {N_SRC{1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         clr_s[i] = (wr_pend_s && Din[i]) || (wr_claim_s && (Din[2:0] == 3'(i)));
      end
   end

   assign rise_s = cur_q & ~prev_q;

   // Pending next state: level sources mirror the sample, edge sources latch rises and a rise beats a clear.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < N_SRC; i++) begin
         if (edge_q[i]) begin
            pend_d[i] = rise_s[i] | (pend_q[i] & ~clr_s[i]);
         end else begin
            pend_d[i] = cur_q[i];
         end
      end
   end

   // MASK and EDGE next state.
   always_comb begin
      mask_d = mask_q;
      edge_d = edge_q;
      if (wr_mask_s) begin
         mask_d = Din[N_SRC-1:0];
      end else begin
         mask_d = mask_q;
      end
      if (wr_edge_s) begin
         edge_d = Din[N_SRC-1:0];
      end else begin
         edge_d = edge_q;
      end
   end

   // State registers; prev starts at 0 so a source high at release reads as a rise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_q  <= {N_SRC{1'b0}};
         prev_q <= {N_SRC{1'b0}};
         pend_q <= {N_SRC{1'b0}};
         mask_q <= MASK_RST[N_SRC-1:0];
         edge_q <= EDGE_RST[N_SRC-1:0];
      end else begin
         cur_q  <= sample_s;
         prev_q <= cur_q;
         pend_q <= pend_d;
         mask_q <= mask_d;
         edge_q <= edge_d;
      end
   end

   assign hwint   = pend_q & mask_q;
   assign irq     = |hwint;
   assign claim_s = {irq, 28'h000_0000, lowest_idx(hwint)};

   // Read mux; reads reflect current register contents only.
   always_comb begin
      Dout = 32'h0000_0000;
      case (sel_s)
         REG_PEND:  Dout = {{(32 - N_SRC){1'b0}}, pend_q};
         REG_MASK:  Dout = {{(32 - N_SRC){1'b0}}, mask_q};
         REG_EDGE:  Dout = {{(32 - N_SRC){1'b0}}, edge_q};
         REG_CLAIM: Dout = claim_s;
         default:   Dout = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_intc_ctrl.sv
// Self-checking bench for intc_ctrl: scoreboard of expected read/output values, one check task.
module tb_intc_ctrl;
`ifdef INTC_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        reset;
   logic [5:0]  src_irq;
   logic [5:0]  src2;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout, Dout2;
   logic [5:0]  hwint, hwint2;
   logic        irq, irq2;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb[$];

   intc_ctrl #(.N_SRC(6), .MASK_RST(8'h00), .EDGE_RST(8'h00)) dut (
      .clk(clk), .reset(reset), .src_irq(src_irq), .Addr(Addr), .WE(WE),
      .Din(Din), .Dout(Dout), .hwint(hwint), .irq(irq)
   );

   intc_ctrl #(.N_SRC(6), .MASK_RST(8'h00), .EDGE_RST(8'h3F)) dut2 (
      .clk(clk), .reset(reset), .src_irq(src2), .Addr(Addr), .WE(WE),
      .Din(Din), .Dout(Dout2), .hwint(hwint2), .irq(irq2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = {28'h000_0000, a};
      Din  = d;
      WE   = 1'b1;
      tick();
      WE   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] e);
      sb.push_back(e);
      Addr = {28'h000_0000, a};
      #1;
      chk(tag, Dout, sb.pop_front());
   endtask

   task automatic rd2(input string tag, input logic [1:0] a, input logic [31:0] e);
      sb.push_back(e);
      Addr = {28'h000_0000, a};
      #1;
      chk(tag, Dout2, sb.pop_front());
   endtask

   task automatic hw(input string tag, input logic [5:0] e);
      sb.push_back({26'h0, e});
      #1;
      chk(tag, {26'h0, hwint}, sb.pop_front());
      chk({tag, "_irq"}, {31'h0, irq}, {31'h0, |e});
   endtask

   initial begin
      reset = 1'b0; src_irq = 6'h00; src2 = 6'h04;
      Addr = 30'h0; WE = 1'b0; Din = 32'h0;
      tick(); tick();
      rd("rst_pend", 2'd0, 32'h0);
      rd("rst_mask", 2'd1, 32'h0);
      rd("rst_edge", 2'd2, 32'h0);
      rd("rst_claim", 2'd3, 32'h0);
      tick();
      hw("rst_hw", 6'h00);
      rd2("rst2_edge", 2'd2, 32'h0000_003F);
      rd2("rst2_pend", 2'd0, 32'h0);
      tick();
      reset = 1'b1;
      repeat (LAT - 1) tick();
      rd2("rel2_pend_early", 2'd0, 32'h0);
      tick();
      rd2("rel2_pend", 2'd0, 32'h0000_0004);
      chk("rel2_hw", {26'h0, hwint2, 1'b0, 31'h0} == 64'h0 ? {31'h0, irq2} : 32'hFFFF_FFFF, 32'h0);
      rd("rel_pend", 2'd0, 32'h0);
      rd("rel_claim", 2'd3, 32'h0);
      hw("rel_hw", 6'h00);

      // level-triggered source
      wr(2'd1, 32'h0000_003F);
      src_irq = 6'h02;
      repeat (LAT - 1) tick();
      hw("lvl_early", 6'h00);
      tick();
      hw("lvl_on", 6'h02);
      wr(2'd0, 32'h0000_0002);
      rd("lvl_w1c", 2'd0, 32'h0000_0002);
      tick();
      rd("lvl_w1c2", 2'd0, 32'h0000_0002);
      src_irq = 6'h00;
      repeat (LAT - 1) tick();
      hw("lvl_hold", 6'h02);
      tick();
      hw("lvl_off", 6'h00);

      // edge-triggered source
      wr(2'd2, 32'h0000_0001);
      wr(2'd1, 32'h0000_0001);
      src_irq = 6'h01;
      tick();
      src_irq = 6'h00;
      repeat (LAT - 1) tick();
      rd("edg_set", 2'd0, 32'h0000_0001);
      hw("edg_hw", 6'h01);
      tick(); tick();
      rd("edg_held", 2'd0, 32'h0000_0001);
      wr(2'd0, 32'h0000_0001);
      rd("edg_clr", 2'd0, 32'h0);
      src_irq = 6'h01;
      tick();
      src_irq = 6'h00;
      repeat (LAT - 2) tick();
      wr(2'd0, 32'h0000_0001);
      rd("edg_setwins", 2'd0, 32'h0000_0001);
      wr(2'd0, 32'h0000_0001);
      rd("edg_clr2", 2'd0, 32'h0);

      // priority and claim
      wr(2'd2, 32'h0000_003F);
      wr(2'd1, 32'h0000_003C);
      src_irq = 6'h2A;
      tick();
      src_irq = 6'h00;
      repeat (LAT - 1) tick();
      rd("pri_pend", 2'd0, 32'h0000_002A);
      hw("pri_hw", 6'h28);
      rd("claim0", 2'd3, 32'h8000_0003);
      Addr = 30'd3; Din = 32'd3; WE = 1'b1;
      #1;
      chk("claim_prewrite", Dout, 32'h8000_0003);
      tick();
      WE = 1'b0;
      rd("claim1", 2'd3, 32'h8000_0005);
      wr(2'd3, 32'd5);
      rd("claim2", 2'd3, 32'h0);
      hw("claim_hw", 6'h00);
      rd("claim_pend", 2'd0, 32'h0000_0002);

      // boundaries
      wr(2'd3, 32'd7);
      rd("ack7_pend", 2'd0, 32'h0000_0002);
      rd("ack7_mask", 2'd1, 32'h0000_003C);
      wr(2'd3, 32'd1);
      rd("ack1_pend", 2'd0, 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      rd("mask_all", 2'd1, 32'h0000_003F);
      wr(2'd2, 32'h0);
      src_irq = 6'h01;
      repeat (LAT) tick();
      rd("lvl0_pend", 2'd0, 32'h0000_0001);
      wr(2'd3, 32'd0);
      rd("lvl0_ack", 2'd0, 32'h0000_0001);
      rd("lvl0_claim", 2'd3, 32'h8000_0000);

      // reset in the middle of activity
      reset = 1'b0;
      #1;
      rd("mid_mask", 2'd1, 32'h0);
      rd("mid_pend", 2'd0, 32'h0);
      hw("mid_hw", 6'h00);
      tick();
      reset = 1'b1;
      src_irq = 6'h00;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
